// File: rtl/cdb_pkg.sv
// cdb_pkg: shared widths, FU ids and broadcast record for the CDB arbiter
package cdb_pkg;
  localparam int NUM_FU = 4;
  localparam int CDB_DATA_W = 64;
  localparam int REG_ID_W = 5;
  localparam int ISS_ID_W = 32;
  localparam int PTR_W = 3;
  typedef enum logic [1:0] {
    ALU = 2'd0,
    MEM = 2'd1,
    BRANCH = 2'd2,
    MULDIV = 2'd3
  } fu_id_e;
  typedef struct packed {
    logic [CDB_DATA_W-1:0] data;
    logic [REG_ID_W-1:0] reg_id;
    logic [ISS_ID_W-1:0] iss_id;
    logic [3:0] fu_id;
  } bcast_t;
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx, input int n);
    return (int'(idx) + 1 >= n) ? '0 : idx + 1'b1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set request at or after the pointer, wrapping, as one-hot and index
module rr_pick
  import cdb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_hit
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  logic [IW-1:0] w_j;
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_hit = 1'b0;
    w_j = '0;
    for (int k = 0; k < N; k++) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      if (!o_hit && i_req[w_j]) begin
        o_hit = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx = PTR_W'(w_j);
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB grant with starvation override and a registered broadcast stage
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_FU = cdb_pkg::NUM_FU,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  ROB_FULL,
  input  logic [NUM_FU-1:0]     CDB_REQ,
  output logic [NUM_FU-1:0]     CDB_ACK,
  input  logic [CDB_DATA_W-1:0] CDB,
  input  logic [REG_ID_W-1:0]   CDB_REG_ID,
  input  logic [ISS_ID_W-1:0]   CDB_ISS_ID,
  output logic                  bcast_valid,
  output logic [CDB_DATA_W-1:0] bcast_data,
  output logic [REG_ID_W-1:0]   bcast_reg_id,
  output logic [ISS_ID_W-1:0]   bcast_iss_id,
  output logic [3:0]            bcast_fu_id,
  output logic                  starve
);
  logic [PTR_W-1:0] r_ptr;
  logic [3:0] r_wait [NUM_FU];
  logic r_valid;
  bcast_t r_bc;
  logic w_en, w_any;
  logic [NUM_FU-1:0] w_over, w_starve_req, w_rr_gnt, w_st_gnt;
  logic [PTR_W-1:0] w_rr_idx, w_st_idx, w_idx;
  logic w_rr_hit, w_st_hit;
  always_comb begin
    w_over = '0;
    for (int i = 0; i < NUM_FU; i++) w_over[i] = r_wait[i] >= 4'(STARVE_LIMIT);
  end
  assign w_starve_req = CDB_REQ & w_over;
  assign w_en = reset && !flush && !ROB_FULL;
  rr_pick #(.N(NUM_FU)) u_rr (
    .i_req(CDB_REQ),
    .i_ptr(r_ptr),
    .o_gnt(w_rr_gnt),
    .o_idx(w_rr_idx),
    .o_hit(w_rr_hit)
  );
  // pointer pinned at 0 turns the same picker into a lowest-index-first search
  rr_pick #(.N(NUM_FU)) u_st (
    .i_req(w_starve_req),
    .i_ptr(PTR_W'(0)),
    .o_gnt(w_st_gnt),
    .o_idx(w_st_idx),
    .o_hit(w_st_hit)
  );
  assign CDB_ACK = !w_en ? '0 : w_st_hit ? w_st_gnt : w_rr_gnt;
  assign w_idx = w_st_hit ? w_st_idx : w_rr_idx;
  assign w_any = w_en && (w_st_hit || w_rr_hit);
  assign starve = reset && |w_over;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr <= '0;
      r_valid <= 1'b0;
      r_bc <= '0;
      for (int i = 0; i < NUM_FU; i++) r_wait[i] <= '0;
    end else begin
      r_valid <= w_any;
      if (w_any) begin
        r_ptr <= next_ptr(w_idx, NUM_FU);
        r_bc <= '{data: CDB, reg_id: CDB_REG_ID, iss_id: CDB_ISS_ID, fu_id: 4'(w_idx)};
      end
      for (int i = 0; i < NUM_FU; i++)
        r_wait[i] <= (flush || !CDB_REQ[i] || CDB_ACK[i]) ? '0 :
                     (r_wait[i] == 4'hF) ? r_wait[i] : r_wait[i] + 1'b1;
    end
  end
  assign bcast_valid = r_valid;
  assign bcast_data = r_bc.data;
  assign bcast_reg_id = r_bc.reg_id;
  assign bcast_iss_id = r_bc.iss_id;
  assign bcast_fu_id = r_bc.fu_id;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vectors queued as expectations, checked by an independent negedge monitor
module tb_cdb_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b0, flush = 1'b0, rob_full = 1'b0;
  logic [3:0] req = '0, sreq = '0;
  logic [63:0] bus = '0;
  logic [4:0] rid = '0;
  logic [31:0] iid = '0;
  logic [3:0] ack, bfu, sack, sbfu;
  logic bv, st, sbv, sst;
  logic [63:0] bd, sbd;
  logic [4:0] br, sbr;
  logic [31:0] bi, sbi;
  cdb_arbiter u_dut (
    .clk(clk), .reset(reset), .flush(flush), .ROB_FULL(rob_full),
    .CDB_REQ(req), .CDB_ACK(ack), .CDB(bus), .CDB_REG_ID(rid), .CDB_ISS_ID(iid),
    .bcast_valid(bv), .bcast_data(bd), .bcast_reg_id(br), .bcast_iss_id(bi),
    .bcast_fu_id(bfu), .starve(st)
  );
  cdb_arbiter #(.STARVE_LIMIT(2)) u_st (
    .clk(clk), .reset(reset), .flush(flush), .ROB_FULL(rob_full),
    .CDB_REQ(sreq), .CDB_ACK(sack), .CDB(bus), .CDB_REG_ID(rid), .CDB_ISS_ID(iid),
    .bcast_valid(sbv), .bcast_data(sbd), .bcast_reg_id(sbr), .bcast_iss_id(sbi),
    .bcast_fu_id(sbfu), .starve(sst)
  );
  typedef struct {
    string name;
    logic [3:0] ack, fu, sack;
    logic bv, st, sst;
    logic [63:0] d;
    logic [4:0] r;
    logic [31:0] i;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0, cnt = 0;
  logic mbv = 1'b0;
  logic [3:0] mfu = '0;
  logic [63:0] md = '0;
  logic [4:0] mr = '0;
  logic [31:0] mi = '0;
  task automatic chk(input string n, input string f, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s %s: got %h expected %h", n, f, a, e);
    end
  endtask
  always @(negedge clk) if (q.size() != 0) begin : mon
    exp_t e;
    e = q.pop_front();
    chk(e.name, "ack", 64'(ack), 64'(e.ack));
    chk(e.name, "ack_legal", 64'($onehot0(ack) && ((ack & ~req) == 4'b0)), 64'd1);
    chk(e.name, "bcast_valid", 64'(bv), 64'(e.bv));
    chk(e.name, "bcast_fu_id", 64'(bfu), 64'(e.fu));
    chk(e.name, "bcast_data", bd, e.d);
    chk(e.name, "bcast_reg_id", 64'(br), 64'(e.r));
    chk(e.name, "bcast_iss_id", 64'(bi), 64'(e.i));
    chk(e.name, "starve", 64'(st), 64'(e.st));
    chk(e.name, "s_ack", 64'(sack), 64'(e.sack));
    chk(e.name, "s_starve", 64'(sst), 64'(e.sst));
  end
  task automatic cyc(input string n, input logic rstn, input logic fl, input logic rf,
                     input logic [3:0] r, input logic [3:0] s, input bit dead,
                     input logic [3:0] eack, input logic est,
                     input logic [3:0] esack, input logic esst);
    exp_t e;
    @(posedge clk);
    #1;
    cnt++;
    reset = rstn; flush = fl; rob_full = rf; req = r; sreq = s;
    bus = dead ? 64'h0000_0000_DEAD_BEEF : {32'hC0DE_0000, 32'(cnt)};
    rid = dead ? 5'd7 : 5'(cnt);
    iid = dead ? 32'd42 : 32'(cnt) + 32'd1000;
    e.name = n; e.ack = eack; e.fu = mfu; e.sack = esack;
    e.bv = mbv; e.st = est; e.sst = esst; e.d = md; e.r = mr; e.i = mi;
    q.push_back(e);
    if (!rstn) begin
      mbv = 1'b0; mfu = '0; md = '0; mr = '0; mi = '0;
    end else begin
      mbv = |eack;
      if (|eack) begin
        md = bus; mr = rid; mi = iid;
        for (int k = 0; k < 4; k++) if (eack[k]) mfu = 4'(k);
      end
    end
  endtask
  initial begin
    // name rstn fl rf req sreq dead | ack st sack sst
    cyc("rst0",      0,0,0,4'b1111,4'b1111,0, 4'b0000,0, 4'b0000,0);
    cyc("rst1",      0,0,0,4'b1111,4'b1111,0, 4'b0000,0, 4'b0000,0);
    cyc("rr0",       1,0,0,4'b1111,4'b0000,0, 4'b0001,0, 4'b0000,0);
    cyc("rr1",       1,0,0,4'b1111,4'b0000,0, 4'b0010,0, 4'b0000,0);
    cyc("rr2",       1,0,0,4'b1111,4'b0000,0, 4'b0100,0, 4'b0000,0);
    cyc("rr3",       1,0,0,4'b1111,4'b0000,0, 4'b1000,0, 4'b0000,0);
    cyc("rr4",       1,0,0,4'b1111,4'b0000,0, 4'b0001,0, 4'b0000,0);
    cyc("idle0",     1,0,0,4'b0000,4'b0000,0, 4'b0000,0, 4'b0000,0);
    cyc("robf0",     1,0,1,4'b0110,4'b0000,0, 4'b0000,0, 4'b0000,0);
    cyc("robf1",     1,0,1,4'b0110,4'b0000,0, 4'b0000,0, 4'b0000,0);
    cyc("robf2",     1,0,1,4'b0110,4'b0000,0, 4'b0000,0, 4'b0000,0);
    cyc("rob_rel",   1,0,0,4'b0110,4'b0000,0, 4'b0010,0, 4'b0000,0);
    cyc("rob_fu2",   1,0,0,4'b0100,4'b0000,0, 4'b0100,0, 4'b0000,0);
    cyc("idle1",     1,0,0,4'b0000,4'b0000,0, 4'b0000,0, 4'b0000,0);
    cyc("bus_gnt",   1,0,0,4'b0010,4'b0000,1, 4'b0010,0, 4'b0000,0);
    cyc("bus_chk",   1,0,0,4'b0000,4'b0000,0, 4'b0000,0, 4'b0000,0);
    cyc("flush",     1,1,0,4'b0010,4'b0000,0, 4'b0000,0, 4'b0000,0);
    cyc("post_fl",   1,0,0,4'b1010,4'b0000,0, 4'b1000,0, 4'b0000,0);
    cyc("post_fl2",  1,0,0,4'b0010,4'b0000,0, 4'b0010,0, 4'b0000,0);
    cyc("idle2",     1,0,0,4'b0000,4'b0000,0, 4'b0000,0, 4'b0000,0);
    cyc("stv1",      1,0,0,4'b0000,4'b0111,0, 4'b0000,0, 4'b0001,0);
    cyc("stv2",      1,0,0,4'b0000,4'b0111,0, 4'b0000,0, 4'b0010,0);
    cyc("stv3",      1,0,0,4'b0000,4'b0111,0, 4'b0000,0, 4'b0100,1);
    cyc("stv4",      1,0,0,4'b0000,4'b0111,0, 4'b0000,0, 4'b0001,1);
    cyc("stv5",      1,0,0,4'b0000,4'b0111,0, 4'b0000,0, 4'b0010,1);
    cyc("stv_drop",  1,0,0,4'b0000,4'b0000,0, 4'b0000,0, 4'b0000,1);
    cyc("ovr1",      1,0,1,4'b0000,4'b0101,0, 4'b0000,0, 4'b0000,0);
    cyc("ovr2",      1,0,1,4'b0000,4'b0101,0, 4'b0000,0, 4'b0000,0);
    cyc("ovr_pick",  1,0,0,4'b0000,4'b0101,0, 4'b0000,0, 4'b0001,1);
    cyc("ovr_next",  1,0,0,4'b0000,4'b0100,0, 4'b0000,0, 4'b0100,1);
    cyc("fwc1",      1,0,1,4'b0000,4'b0001,0, 4'b0000,0, 4'b0000,0);
    cyc("fwc2",      1,0,1,4'b0000,4'b0001,0, 4'b0000,0, 4'b0000,0);
    cyc("fwc_flush", 1,1,0,4'b0000,4'b0001,0, 4'b0000,0, 4'b0000,1);
    cyc("fwc_after", 1,0,0,4'b0000,4'b0001,0, 4'b0000,0, 4'b0001,0);
    cyc("idle3",     1,0,0,4'b0000,4'b0000,0, 4'b0000,0, 4'b0000,0);
    cyc("mid_gnt",   1,0,0,4'b0100,4'b0000,0, 4'b0100,0, 4'b0000,0);
    cyc("mid_rst",   0,0,0,4'b0100,4'b0000,0, 4'b0000,0, 4'b0000,0);
    cyc("rst_fu3",   1,0,0,4'b1000,4'b0000,0, 4'b1000,0, 4'b0000,0);
    cyc("rst_bc",    1,0,0,4'b0000,4'b0000,0, 4'b0000,0, 4'b0000,0);
    cyc("p_gnt",     1,0,0,4'b0100,4'b0000,0, 4'b0100,0, 4'b0000,0);
    cyc("p_rst",     0,0,0,4'b0000,4'b0000,0, 4'b0000,0, 4'b0000,0);
    cyc("p_zero",    1,0,0,4'b1100,4'b0000,0, 4'b0100,0, 4'b0000,0);
    cyc("idle4",     1,0,0,4'b0000,4'b0000,0, 4'b0000,0, 4'b0000,0);
    @(negedge clk);
    @(negedge clk);
    chk("drain", "pending", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 4, meaning the number of functional-unit requesters on the common data bus (CDB), valid range 2..8.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, meaning the consecutive-cycles-denied threshold for starvation override, valid range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port flush, input, 1 bit: speculative flush; grants are suppressed while it is high.
REQ-006 SHALL have port ROB_FULL, input, 1 bit: grants are suppressed while it is high.
REQ-007 SHALL have port CDB_REQ, input, NUM_FU bits: bit i is the request from FU i.
REQ-008 SHALL have port CDB_ACK, output, NUM_FU bits: one-hot or zero grant vector.
REQ-009 SHALL have port CDB, input, 64 bits: shared result bus, driven by the granted FU.
REQ-010 SHALL have port CDB_REG_ID, input, 5 bits: shared destination register id.
REQ-011 SHALL have port CDB_ISS_ID, input, 32 bits: shared issue/WAW id.
REQ-012 SHALL have port bcast_valid, output, 1 bit: registered broadcast strobe.
REQ-013 SHALL have ports bcast_data (output, 64 bits), bcast_reg_id (output, 5 bits) and bcast_iss_id (output, 32 bits): the latched bus contents.
REQ-014 SHALL have port bcast_fu_id, output, 4 bits: the FU index of the latched grant.
REQ-015 SHALL have port starve, output, 1 bit: high while any requester's wait count is at or above STARVE_LIMIT.

Function
REQ-016 CDB_ACK SHALL be combinational from CDB_REQ and state, so the grant appears in the same cycle as the request.
REQ-017 CDB_ACK SHALL have at most one bit set, and that bit SHALL be set only where the corresponding CDB_REQ bit is high.
REQ-018 When flush or ROB_FULL is high, CDB_ACK SHALL be all zero.
REQ-019 Grant selection SHALL be round-robin: the first requesting index at or after the pointer ptr, wrapping at NUM_FU-1 to 0.
REQ-020 After a grant to FU i, ptr SHALL become (i+1) mod NUM_FU; with no grant, ptr SHALL hold.
REQ-021 Each FU i SHALL have a wait counter that increments (saturating at 15) in every cycle it requests without receiving a grant, and clears when it is granted or when it deasserts its request.
REQ-022 Starvation override: if any wait counter is at or above STARVE_LIMIT, the lowest-index such requester SHALL be granted, ignoring ptr; ptr SHALL still update per REQ-020.
REQ-023 A requester SHALL hold CDB_REQ high until it receives CDB_ACK; a request dropped without ack is a protocol violation.
REQ-024 The arbiter SHALL take no action on such a violation other than clearing that FU's wait counter.
REQ-025 On a rising edge with CDB_ACK nonzero, the arbiter SHALL register CDB, CDB_REG_ID, CDB_ISS_ID and the granted index into bcast_*, and set bcast_valid=1 for exactly the next cycle.
REQ-026 Broadcast latency SHALL be 1 cycle from grant; back-to-back grants SHALL yield back-to-back bcast_valid.
REQ-027 When flush is high at a rising edge, bcast_valid SHALL be 0 in the following cycle and all wait counters SHALL clear.
REQ-028 ptr SHALL be preserved through a flush.
REQ-029 If flush and a request occur in the same cycle, the flush SHALL win.
REQ-030 The arbiter SHALL never drive CDB, CDB_REG_ID or CDB_ISS_ID; it only samples them.

Reset
REQ-031 While reset=0 at a rising edge: ptr=0, all wait counters=0, bcast_valid=0, bcast_data=0, bcast_reg_id=0, bcast_iss_id=0, bcast_fu_id=0.
REQ-032 While reset=0, CDB_ACK and starve SHALL be 0 combinationally.
REQ-033 A reset asserted mid-grant SHALL discard the pending broadcast, so bcast_valid=0 in the next cycle.

Structure
REQ-034 A shared package cdb_pkg SHALL hold NUM_FU, the FU id constants (ALU=0, MEM=1, BRANCH=2, MULDIV=3), CDB_DATA_W=64, REG_ID_W=5 and ISS_ID_W=32.
REQ-035 The rotate-and-priority-pick logic SHALL be a single sub-module, rr_pick (inputs: request vector and pointer; outputs: one-hot grant and index).
REQ-036 The expected implementation size is 150-250 lines of RTL.

Verification
REQ-037 CDB_REQ=4'b1111 held with flush=0 and ROB_FULL=0 -> CDB_ACK SHALL cycle 0001, 0010, 0100, 1000, 0001, with bcast_fu_id following 1 cycle later.
REQ-038 CDB_REQ=4'b0110, then ROB_FULL=1 for 3 cycles -> CDB_ACK=0 for those 3 cycles and bcast_valid=0 one cycle later; on ROB_FULL release, FU1 is granted first.
REQ-039 FU2 requests continuously while FU0 and FU1 re-request every cycle, with STARVE_LIMIT=2 and ptr forced to 0 -> FU2 SHALL be granted no later than its 3rd request cycle, with starve=1 in that cycle.
REQ-040 Grant to FU1 with CDB=64'h0000_0000_DEAD_BEEF, CDB_REG_ID=5'd7 and CDB_ISS_ID=32'd42 -> the next cycle SHALL show bcast_valid=1 with those values and bcast_fu_id=1.
REQ-041 flush=1 in the same cycle as CDB_REQ=4'b0010 -> CDB_ACK=0 and bcast_valid=0 next cycle, wait counters 0, ptr unchanged.
REQ-042 reset=0 asserted for 1 cycle during a grant -> bcast_valid=0 next cycle and ptr=0; with CDB_REQ=4'b1000 after release, FU3 SHALL be granted.
